// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usr_pkg
//  Desc     : Shared encodings for the universal shift-register sequencer:
//             command opcodes, FSM states, datapath selects, default width.
//  Revision : 1.0 - initial release
// ============================================================================
package usr_pkg;

    // Default register width in bits
    localparam int USR_DEF_WIDTH = 8;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_SHR   = 2'b01,
        OP_SHL   = 2'b10,
        OP_LOAD  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Per-cycle action requested from the shift datapath
    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_e;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_core.sv
`default_nettype none
// ============================================================================
//  Module   : usr_core
//  Desc     : Shift datapath: holds the register and the last expelled bit.
//             Performs exactly one action per clock as chosen by sel.
//  Revision : 1.0 - initial release
// ============================================================================
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  sel_e             sel,
    input  logic             fill,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out
);

    logic [WIDTH-1:0] reg_q;
    logic             ser_q;

    // Register update: load, shift one place with fill, or hold
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            reg_q <= '0;
            ser_q <= 1'b0;
        end else begin
            case (sel)
                SEL_LOAD: begin
                    reg_q <= data_in;
                end
                SEL_SHR: begin
                    reg_q <= {fill, reg_q[WIDTH-1:1]};
                    ser_q <= reg_q[0];
                end
                SEL_SHL: begin
                    reg_q <= {reg_q[WIDTH-2:0], fill};
                    ser_q <= reg_q[WIDTH-1];
                end
                default: begin
                    reg_q <= reg_q;
                    ser_q <= ser_q;
                end
            endcase
        end
    end

    assign data_out = reg_q;
    assign ser_out  = ser_q;

endmodule : usr_core
`default_nettype wire

// File: rtl/usr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : usr_seq
//  Desc     : Command sequencer for a universal shift register. Accepts one
//             command at a time (NOP / shift right / shift left / load),
//             counts shifts with pause support and pulses done on completion.
//  Revision : 1.0 - initial release
// ============================================================================
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CW-1:0]    cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_rot,
    input  logic             ser_in,
    input  logic             pause,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] C_WIDTH_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);

    state_e           state_q;
    op_e              op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             rot_q;
    logic             done_q;
    logic             busy_q;

    logic [CW-1:0]    cnt_sat_d;
    logic             is_shift_d;
    sel_e             sel_d;
    logic             expelled_d;
    logic             fill_d;

    // Requested shift count clipped to the register width at accept time
    always_comb begin
        cnt_sat_d  = (cmd_cnt > C_WIDTH_CNT) ? C_WIDTH_CNT : cmd_cnt;
        is_shift_d = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);
    end

    // Sequencer FSM with shift counter; done/busy are registered with state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            data_q  <= '0;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= op_e'(cmd_op);
                        cnt_q  <= cnt_sat_d;
                        data_q <= cmd_data;
                        rot_q  <= cmd_rot;
                        busy_q <= 1'b1;
                        if (cmd_op == OP_LOAD) begin
                            state_q <= ST_LOAD;
                        end else if (is_shift_d && (cnt_sat_d != '0)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_SHIFT: begin
                    if (!pause) begin
                        cnt_q <= cnt_q - C_CNT_ONE;
                        if (cnt_q == C_CNT_ONE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE lasts a single cycle, then back to IDLE
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath action for this cycle: load in LOAD, shift in unpaused SHIFT
    always_comb begin
        sel_d = SEL_HOLD;
        case (state_q)
            ST_LOAD:  sel_d = SEL_LOAD;
            ST_SHIFT: begin
                if (!pause) begin
                    sel_d = (op_q == OP_SHL) ? SEL_SHL : SEL_SHR;
                end
            end
            default:  sel_d = SEL_HOLD;
        endcase
    end

    // Fill bit: the bit leaving the register when rotating, else serial input
    always_comb begin
        expelled_d = (op_q == OP_SHL) ? data_out[WIDTH-1] : data_out[0];
        fill_d     = rot_q ? expelled_d : ser_in;
    end

    usr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .clr_n    (clr_n),
        .sel      (sel_d),
        .fill     (fill_d),
        .data_in  (data_q),
        .data_out (data_out),
        .ser_out  (ser_out)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : usr_seq
`default_nettype wire

// File: tb/tb_usr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usr_seq
//  Desc     : Directed self-checking bench for usr_seq with a scoreboard of
//             expected register value, serial output and latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usr_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          clr_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'b00;
    logic [CW-1:0] cmd_cnt   = '0;
    logic [W-1:0]  cmd_data  = '0;
    logic          cmd_rot   = 1'b0;
    logic          ser_in    = 1'b0;
    logic          pause     = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: what the register and ser_out should hold
    logic [W-1:0] exp_data = '0;
    logic         exp_ser  = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        int           lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    usr_seq #(
        .WIDTH (W),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_rot   (cmd_rot),
        .ser_in    (ser_in),
        .pause     (pause),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural model of one command applied to exp_data / exp_ser
    function automatic void model(input logic [1:0] op, input logic [CW-1:0] cnt,
                                  input logic [W-1:0] d, input logic rot, input logic sin);
        int   n;
        logic b;
        n = (int'(cnt) > W) ? W : int'(cnt);
        case (op)
            2'b11: exp_data = d;
            2'b01: begin
                for (int i = 0; i < n; i++) begin
                    b        = exp_data[0];
                    exp_data = {(rot ? b : sin), exp_data[W-1:1]};
                    exp_ser  = b;
                end
            end
            2'b10: begin
                for (int i = 0; i < n; i++) begin
                    b        = exp_data[W-1];
                    exp_data = {exp_data[W-2:0], (rot ? b : sin)};
                    exp_ser  = b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one command, optionally pause / inject an ignored command, and
    // compare the completion against the scoreboard entry
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [CW-1:0] cnt,
                          input logic [W-1:0] d, input logic rot, input logic sin,
                          input int p_at, input int p_len, input bit junk);
        exp_t e;
        exp_t got;
        int   n;
        int   c;
        int   busy_n;
        bit   seen;
        n = (int'(cnt) > W) ? W : int'(cnt);
        if (op == 2'b11)                  e.lat = 2;
        else if (op == 2'b00 || n == 0)   e.lat = 1;
        else                              e.lat = n + 1 + p_len;
        model(op, cnt, d, rot, sin);
        e.d = exp_data;
        e.s = exp_ser;
        sb.push_back(e);

        check({tag, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = d;
        cmd_rot   = rot;
        ser_in    = sin;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = ~d;

        c      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (c < 100 && !seen) begin
            c++;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                pause = (p_len > 0) && (c >= p_at) && (c < p_at + p_len);
                if (junk && c == 1) begin
                    cmd_valid = 1'b1;
                    cmd_op    = 2'b11;
                    cmd_data  = 8'hFF;
                end else begin
                    cmd_valid = 1'b0;
                end
                tick();
            end
        end
        pause     = 1'b0;
        cmd_valid = 1'b0;

        check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, " data_out"}, {24'd0, data_out}, {24'd0, got.d});
            check({tag, " ser_out"},  {31'd0, ser_out},  {31'd0, got.s});
            check({tag, " latency"},  c,                 got.lat);
            check({tag, " busy_cycles"}, busy_n,         got.lat);
            tick();
            check({tag, " done_one_cycle"}, {31'd0, done},      32'd0);
            check({tag, " ready_after"},    {31'd0, cmd_ready}, 32'd1);
            check({tag, " data_held"},      {24'd0, data_out},  {24'd0, got.d});
        end
    endtask

    initial begin
        int done_cnt;

        // Reset state
        #12;
        check("rst data_out", {24'd0, data_out}, 32'd0);
        check("rst ser_out",  {31'd0, ser_out},  32'd0);
        check("rst busy",     {31'd0, busy},     32'd0);
        check("rst done",     {31'd0, done},     32'd0);
        #11;
        clr_n = 1'b1;
        tick();
        check("rst ready", {31'd0, cmd_ready}, 32'd1);

        // Load, shift right with serial fill, rotate left full turn
        do_cmd("load_a5",  2'b11, 4'd0, 8'hA5, 1'b0, 1'b0, 0, 0, 1'b0);
        do_cmd("load_81",  2'b11, 4'd0, 8'h81, 1'b0, 1'b0, 0, 0, 1'b0);
        do_cmd("shr3",     2'b01, 4'd3, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0);
        do_cmd("load_81b", 2'b11, 4'd0, 8'h81, 1'b0, 1'b0, 0, 0, 1'b0);
        do_cmd("rotl8",    2'b10, 4'd8, 8'h00, 1'b1, 1'b0, 0, 0, 1'b1);

        // Paused shift left: latency grows by the paused cycles only
        do_cmd("load_3c",  2'b11, 4'd0, 8'h3C, 1'b0, 1'b0, 0, 0, 1'b0);
        do_cmd("shl4_pause", 2'b10, 4'd4, 8'h00, 1'b0, 1'b0, 2, 3, 1'b0);

        // Count boundaries: zero and saturation
        do_cmd("shr0",     2'b01, 4'd0,  8'h00, 1'b0, 1'b1, 0, 0, 1'b0);
        do_cmd("load_5a",  2'b11, 4'd0,  8'h5A, 1'b0, 1'b0, 0, 0, 1'b0);
        do_cmd("shr15",    2'b01, 4'd15, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0);

        // NOP and pause outside SHIFT
        do_cmd("nop5",       2'b00, 4'd5, 8'h12, 1'b0, 1'b0, 0, 0, 1'b0);
        do_cmd("load_pause", 2'b11, 4'd0, 8'hC3, 1'b0, 1'b0, 1, 2, 1'b0);

        // Reset during second shift of five
        do_cmd("load_e7",  2'b11, 4'd0, 8'hE7, 1'b0, 1'b0, 0, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 4'd5;
        cmd_rot   = 1'b0;
        ser_in    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        #2;
        clr_n = 1'b0;
        #1;
        check("midrst data_out", {24'd0, data_out}, 32'd0);
        check("midrst ser_out",  {31'd0, ser_out},  32'd0);
        check("midrst busy",     {31'd0, busy},     32'd0);
        check("midrst done",     {31'd0, done},     32'd0);
        tick();
        tick();
        clr_n    = 1'b1;
        exp_data = '0;
        exp_ser  = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("midrst no_done", done_cnt, 32'd0);
        check("midrst ready",   {31'd0, cmd_ready}, 32'd1);
        check("midrst data_held", {24'd0, data_out}, 32'd0);
        do_cmd("load_after_rst", 2'b11, 4'd0, 8'h66, 1'b0, 1'b0, 0, 0, 1'b0);

        // A few pseudo-random commands
        for (int i = 0; i < 6; i++) begin
            do_cmd("rand", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_usr_seq
`default_nettype wire

// File: doc/usr_seq.md
USR_SEQ -- requirements
Module: usr_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL provide parameter CW, default $clog2(WIDTH)+1, shift-count field width.
REQ-003 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide clr_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide cmd_valid  input  1  command offered.
REQ-006 SHALL provide cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 SHALL provide cmd_op  input  2  00 HOLD-NOP, 01 SHIFT-RIGHT, 10 SHIFT-LEFT, 11 PARALLEL-LOAD.
REQ-008 SHALL provide cmd_cnt  input  CW  number of shifts (0..WIDTH), ignored for LOAD/NOP.
REQ-009 SHALL provide cmd_data  input  WIDTH  parallel load value.
REQ-010 SHALL provide cmd_rot  input  1  1 = rotate (fill bit is the bit shifted out), 0 = fill from ser_in.
REQ-011 SHALL provide ser_in  input  1  serial fill bit, sampled on every shift cycle.
REQ-012 SHALL provide pause  input  1  while high in SHIFT, register and counter hold.
REQ-013 SHALL provide data_out  output  WIDTH  current register contents.
REQ-014 SHALL provide ser_out  output  1  bit expelled by the most recent shift.
REQ-015 SHALL provide busy  output  1  high in any state except IDLE.
REQ-016 SHALL provide done  output  1  single-cycle pulse on command completion.

Function
REQ-017 FSM states IDLE, LOAD, SHIFT, DONE; cmd_ready SHALL equal (state==IDLE), combinationally.
REQ-018 Accept edge (IDLE, cmd_valid=1): SHALL latch op, cnt, data, rot; next state LOAD for op 11, SHIFT for op 01/10 with cnt>0, DONE for op 00 or cnt=0.
REQ-019 LOAD: register SHALL take latched data on the next edge; state -> DONE.
REQ-020 SHIFT, pause=0: each edge SHALL shift once and decrement remaining count; edge with remaining=1 moves to DONE.
REQ-021 SHIFT, pause=1: register, ser_out, count SHALL hold; state stays SHIFT.
REQ-022 Shift right: reg <= {fill, reg[WIDTH-1:1]}, ser_out <= reg[0]; shift left: reg <= {reg[WIDTH-2:0], fill}, ser_out <= reg[WIDTH-1].
REQ-023 fill SHALL be the expelled bit when rot=1, else ser_in sampled that cycle.
REQ-024 DONE SHALL last exactly one cycle with done=1, then IDLE; a new command is accepted no earlier than the following edge.
REQ-025 Latency: LOAD accept->done = 2 cycles; SHIFT of N = N+1 cycles plus paused cycles; NOP/cnt=0 = 1 cycle.
REQ-026 cmd_cnt > WIDTH SHALL be saturated to WIDTH at accept.
REQ-027 Register contents SHALL be unchanged in IDLE and DONE; cmd_valid outside IDLE SHALL be ignored.
REQ-028 pause SHALL have no effect outside SHIFT.

Reset
REQ-029 clr_n low SHALL immediately force state IDLE, data_out 0, ser_out 0, count 0, done 0, busy 0, cmd_ready 1 after release.
REQ-030 Reset asserted mid-command SHALL abandon the command with no done pulse.

Structure
REQ-031 Op encodings, state encoding and the default WIDTH SHALL live in shared package usr_pkg.
REQ-032 The shift datapath SHALL be a sub-module usr_core (sel, fill, data_in, data_out, ser_out, clk, clr_n); usr_seq holds FSM and counter only.

Verification
REQ-033 Reset, then LOAD 8'hA5 -> data_out=8'hA5 two cycles after accept, done pulse one cycle, cmd_ready high after.
REQ-034 LOAD 8'h81, SHIFT-RIGHT cnt=3 rot=0 ser_in=1 -> data_out=8'hF0, ser_out=0, done after 4 cycles.
REQ-035 LOAD 8'h81, SHIFT-LEFT cnt=8 rot=1 -> data_out=8'h81 after 8 shifts, busy 9 cycles.
REQ-036 SHIFT-LEFT cnt=4 with pause high for 3 cycles mid-shift -> done 8 cycles after accept, value equals unpaused result.
REQ-037 SHIFT-RIGHT cnt=0 and cnt=15 (CW=4) -> cnt=0 gives done next cycle, data unchanged; cnt=15 performs exactly 8 shifts.
REQ-038 clr_n pulsed low during shift 2 of 5 -> data_out=0, state IDLE, no done; next LOAD works normally.
